rr_stream_mux: RTL and testbench
================================

# rr_stream_mux

Round-robin N-to-1 stream multiplexer for the digitizer readout path: gathers ADC sample words from N per-channel sources, each with a valid/ready handshake, onto one registered output stream tagged with the source channel index. It is the gathering counterpart of the `demux` channel fan-out. A channel keeps the grant for a bounded burst, so one busy channel cannot starve the others.

## Interface
- `N`, 4: number of input channels. Must be at least 2.
- `W`, 12: sample word width.
- `BURST`, 16: maximum words per grant. Must be at least 1.
- `S = clog2(N)`: derived index width, using the same `clog2` function as `demux`.

- `clk`  in  1  Single clock; all logic is on the rising edge.
- `rst`  in  1  Reset, asynchronous and active-high.
- `in_data`  in  N*W  Channel i occupies bits [i*W +: W].
- `in_valid`  in  N  Per-channel data valid.
- `in_ready`  out  N  Per-channel accept. One-hot or zero.
- `out_data`  out  W  Registered output word.
- `out_chan`  out  S  Source channel of `out_data`.
- `out_last`  out  1  Marks the final word of a full-length burst.
- `out_valid`  out  1  Output word valid.
- `out_ready`  in  1  Downstream accept.

## Operation
- State machine with two states: IDLE and GRANT. Registers: `grant[S-1:0]`, `ptr[S-1:0]` (next priority channel), `cnt` (0..BURST-1).
- IDLE:
  - Search channels `ptr`, `ptr+1`, …, `ptr+N-1`, all mod N, and take the first one with `in_valid` high.
  - If one is found: load `grant` with it, clear `cnt`, go to GRANT.
  - If none is found: stay in IDLE.
  - `in_ready` is all zeros in IDLE.
- GRANT:
  - `slot_free = !out_valid || out_ready`.
  - `in_ready[grant] = slot_free`; every other `in_ready` bit is 0.
  - A transfer `acc = in_valid[grant] && in_ready[grant]`.
- On `acc`:
  - `out_data` <= the granted word, `out_chan` <= `grant`, `out_valid` <= 1.
  - `out_last` <= (`cnt == BURST-1`).
  - `cnt` increments.
- Release conditions. Both send the state machine to IDLE with `ptr` <= `grant+1` mod N, wrapping N-1 to 0:
  - `acc` with `cnt == BURST-1` (burst complete).
  - `slot_free && !in_valid[grant]` (channel ran dry). No word is transferred and `out_last` is not set on the previous word.
- With no `acc`: if `out_ready` is high, `out_valid` <= 0; otherwise the output holds (`out_data`, `out_chan`, `out_last` stable while `out_valid && !out_ready`).
- A stalled output (`!slot_free`) never causes a release, whatever `in_valid` does.
- `in_valid` dropping while the output is stalled is legal. The release is evaluated in the first cycle where `slot_free` is high.
- Input contract: sources hold `in_data` stable while `in_valid && !in_ready`.

## Timing
- Reset values:
  - `out_valid`, `out_last`, `out_data`, `out_chan`, `in_ready` all 0.
  - State IDLE, `ptr=0`, `grant=0`, `cnt=0`.
  - `rst` asserted mid-burst clears everything immediately. The word in the output register is discarded.
- Latency: a word accepted at edge k appears on `out_*` from edge k, so it is visible in cycle k+1. One register stage.
- Grant overhead: one IDLE cycle per grant. The first acceptance happens in the cycle after IDLE.
- Throughput: one word per cycle within a burst while `out_ready` is held high.
- Steady state with all channels continuously valid and `out_ready` high: BURST words per channel, then a 1-cycle gap, then the next channel in order.
- `in_ready` is combinational from state, `out_valid` and `out_ready`. It has no path from `in_valid`.

## Test plan
- Single burst, N=4, BURST=4: ch2 presents words 0x101..0x106 continuously, `out_ready`=1 → output 0x101..0x104 with `out_chan`=2 on consecutive cycles and `out_last` high on 0x104; one gap cycle; 0x105, 0x106; release (ch2 dry); `ptr`=3.
- Fairness: all 4 channels always valid, `out_ready`=1 → `out_chan` sequence of 4×0, 4×1, 4×2, 4×3, 4×0, with exactly one idle cycle between groups and the wrap from 3 to 0.
- Backpressure: `out_ready` low for 5 cycles mid-burst → `out_data`/`out_chan` stable, `in_ready` all 0, no words lost or duplicated; the full sequence matches the source order after release.
- Dry mid-burst: ch1 sends 2 words then drops `in_valid` while ch3 is valid → release after 2 words with `out_last`=0; ch3 granted next, since ch2 is skipped as not valid.
- Reset mid-burst: assert `rst` asynchronously between edges while `out_valid`=1 → `out_valid` and `in_ready` go to 0 without waiting for an edge; after release the first grant goes to the lowest valid channel starting from 0.
- Stall-then-dry: channel drops `in_valid` while `out_ready`=0 → no release until `out_ready`=1, then release with `ptr` = `grant+1`.

Source files
------------

// File: rtl/rr_stream_mux_if.sv
// Stream bundle for rr_stream_mux: N per-channel valid/ready inputs gathered
// onto one channel-tagged output stream.
interface rr_stream_mux_if #(
    parameter int N = 4,
    parameter int W = 12
);
    localparam int S = $clog2(N);

    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic [S-1:0]   out_chan;
    logic           out_last;
    logic           out_valid;
    logic           out_ready;

    // master is the multiplexer side, slave is the sources plus the sink.
    modport master (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_chan, out_last, out_valid
    );

    modport slave (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_chan, out_last, out_valid
    );
endinterface

// File: rtl/rr_stream_mux.sv
// Round-robin N-to-1 stream multiplexer with bounded bursts and a single
// registered output stage tagged with the source channel.
module rr_stream_mux #(
    parameter int N     = 4,
    parameter int W     = 12,
    parameter int BURST = 16
) (
    input  logic             clk,
    input  logic             rst,
    rr_stream_mux_if.master  bus
);
    localparam int S  = $clog2(N);
    localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(BURST - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t         state;
    logic [S-1:0]   grant;
    logic [S-1:0]   ptr;
    logic [CW-1:0]  cnt;

    logic [W-1:0]   data_p0;
    logic [S-1:0]   chan_p0;
    logic           last_p0;
    logic           vld_p0;

    logic           slot_free;
    logic           acc;
    logic           found;
    logic [S-1:0]   pick;
    logic [S-1:0]   next_ptr;

    assign slot_free = !vld_p0 || bus.out_ready;
    assign acc       = (state == GRANT) && bus.in_valid[grant] && slot_free;
    assign next_ptr  = (grant == S'(N - 1)) ? '0 : grant + 1'b1;

    always_comb begin
        bus.in_ready = '0;
        if (state == GRANT && slot_free)
            bus.in_ready[grant] = 1'b1;
    end

    // Scan from the far end back toward ptr so the nearest valid channel wins.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            int j;
            j = int'(ptr) + i;
            if (j >= N)
                j = j - N;
            if (bus.in_valid[j]) begin
                found = 1'b1;
                pick  = S'(j);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            grant   <= '0;
            ptr     <= '0;
            cnt     <= '0;
            data_p0 <= '0;
            chan_p0 <= '0;
            last_p0 <= 1'b0;
            vld_p0  <= 1'b0;
        end else begin
            // output register stage p0
            if (acc) begin
                data_p0 <= bus.in_data[int'(grant)*W +: W];
                chan_p0 <= grant;
                last_p0 <= (cnt == CNT_MAX);
                vld_p0  <= 1'b1;
            end else if (bus.out_ready) begin
                vld_p0  <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (found) begin
                        grant <= pick;
                        cnt   <= '0;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (acc) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_MAX) begin
                            state <= IDLE;
                            ptr   <= next_ptr;
                        end
                    end else if (slot_free && !bus.in_valid[grant]) begin
                        state <= IDLE;
                        ptr   <= next_ptr;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.out_data  = data_p0;
    assign bus.out_chan  = chan_p0;
    assign bus.out_last  = last_p0;
    assign bus.out_valid = vld_p0;
endmodule

// File: tb/tb_rr_stream_mux.sv
// Directed bench for rr_stream_mux (N=4, W=12, BURST=4) with per-channel
// word sources and hand-computed output sequences.
module tb_rr_stream_mux;
    localparam int N     = 4;
    localparam int W     = 12;
    localparam int BURST = 4;
    localparam int S     = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rr_stream_mux_if #(.N(N), .W(W)) bus ();

    rr_stream_mux #(.N(N), .W(W), .BURST(BURST)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int base [N];
    int len  [N];
    int idx  [N];
    int drop_at [N];
    int cyc;
    int stall_lo, stall_hi;

    logic           vld_log [64];
    logic [W-1:0]   dat_log [64];
    logic [N-1:0]   rdy_log [64];
    logic [S-1:0]   ptr_log [64];
    logic [W+S:0]   words [$];
    logic [W+S:0]   exp_q [$];

    function automatic logic [W+S:0] enc(input logic last, input int chan, input int data);
        return {last, S'(chan), W'(data)};
    endfunction

    task automatic drive();
        for (int ch = 0; ch < N; ch++) begin
            bus.in_valid[ch] = (idx[ch] < len[ch]) && (cyc < drop_at[ch]);
            bus.in_data[ch*W +: W] = W'(base[ch] + idx[ch]);
        end
        bus.out_ready = !(cyc >= stall_lo && cyc < stall_hi);
    endtask

    task automatic clear_src();
        for (int ch = 0; ch < N; ch++) begin
            base[ch] = 0; len[ch] = 0; idx[ch] = 0; drop_at[ch] = 1000;
        end
        stall_lo = 0;
        stall_hi = 0;
        cyc = 0;
        words.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        clear_src();
        drive();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic run(input int n);
        logic [N-1:0] hs;
        for (int c = 0; c < n; c++) begin
            cyc = c;
            drive();
            @(negedge clk);
            vld_log[c] = bus.out_valid;
            dat_log[c] = bus.out_data;
            rdy_log[c] = bus.in_ready;
            ptr_log[c] = dut.ptr;
            if (bus.out_valid && bus.out_ready)
                words.push_back({bus.out_last, bus.out_chan, bus.out_data});
            hs = bus.in_valid & bus.in_ready;
            @(posedge clk);
            #1;
            for (int ch = 0; ch < N; ch++)
                if (hs[ch]) idx[ch]++;
        end
    endtask

    task automatic chk_words(input string tag);
        chk({tag, " count"}, words.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s word%0d", tag, i),
                (i < words.size()) ? 32'(words[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
    endtask

    function automatic logic [31:0] vld_bits(input int n);
        logic [31:0] v = '0;
        for (int c = 0; c < n; c++) v = {v[30:0], vld_log[c]};
        return v;
    endfunction

    initial begin
        logic [31:0] ev;
        rst = 1'b0;
        bus.in_valid = '0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;

        // Reset state
        do_reset();
        chk("rst out_valid", bus.out_valid, 0);
        chk("rst out_last",  bus.out_last, 0);
        chk("rst out_data",  bus.out_data, 0);
        chk("rst out_chan",  bus.out_chan, 0);
        chk("rst in_ready",  bus.in_ready, 0);
        chk("rst ptr",       dut.ptr, 0);
        chk("rst grant",     dut.grant, 0);

        // Single burst on ch2, six words
        do_reset();
        base[2] = 'h101; len[2] = 6;
        run(10);
        chk("t1 valid pattern", vld_bits(10), 32'b0011110110);
        exp_q.push_back(enc(0, 2, 'h101)); exp_q.push_back(enc(0, 2, 'h102));
        exp_q.push_back(enc(0, 2, 'h103)); exp_q.push_back(enc(1, 2, 'h104));
        exp_q.push_back(enc(0, 2, 'h105)); exp_q.push_back(enc(0, 2, 'h106));
        chk_words("t1");
        chk("t1 ptr after dry", dut.ptr, 3);

        // Fairness with all channels valid
        do_reset();
        for (int ch = 0; ch < N; ch++) begin base[ch] = ch << 8; len[ch] = 100; end
        run(26);
        ev = '0;
        for (int c = 0; c < 26; c++) ev = {ev[30:0], (c >= 2) && ((c - 2) % 5 != 4)};
        chk("t2 valid pattern", vld_bits(26), ev);
        for (int g = 0; g < 5; g++)
            for (int k = 0; k < 4; k++)
                exp_q.push_back(enc(k == 3, g % 4, ((g % 4) << 8) + (g / 4) * 4 + k));
        chk_words("t2");

        // Backpressure for 5 cycles mid-burst
        do_reset();
        base[1] = 'h210; len[1] = 6;
        stall_lo = 3; stall_hi = 8;
        run(15);
        for (int c = 3; c < 8; c++)
            chk($sformatf("t3 stall c%0d", c), {rdy_log[c], vld_log[c], dat_log[c]},
                {4'b0, 1'b1, 12'h211});
        exp_q.push_back(enc(0, 1, 'h210)); exp_q.push_back(enc(0, 1, 'h211));
        exp_q.push_back(enc(0, 1, 'h212)); exp_q.push_back(enc(1, 1, 'h213));
        exp_q.push_back(enc(0, 1, 'h214)); exp_q.push_back(enc(0, 1, 'h215));
        chk_words("t3");

        // Dry mid-burst: ch1 gives two words, ch3 granted next
        do_reset();
        base[1] = 'h300; len[1] = 2;
        base[3] = 'h3A0; len[3] = 3;
        run(10);
        chk("t4 ptr after dry", ptr_log[4], 2);
        exp_q.push_back(enc(0, 1, 'h300)); exp_q.push_back(enc(0, 1, 'h301));
        exp_q.push_back(enc(0, 3, 'h3A0)); exp_q.push_back(enc(0, 3, 'h3A1));
        exp_q.push_back(enc(0, 3, 'h3A2));
        chk_words("t4");

        // Asynchronous reset mid-burst
        do_reset();
        base[3] = 'h400; len[3] = 10;
        run(4);
        chk("t5 pre-reset valid", bus.out_valid, 1);
        #1 rst = 1'b1;
        #1;
        chk("t5 async out_valid", bus.out_valid, 0);
        chk("t5 async in_ready",  bus.in_ready, 0);
        chk("t5 async out_data",  bus.out_data, 0);
        #1 rst = 1'b0;
        clear_src();
        base[1] = 'h500; len[1] = 5;
        base[3] = 'h400; len[3] = 10;
        run(4);
        chk("t5 first grant", (words.size() > 0) ? 32'(words[0]) : 32'hFFFF_FFFF,
            32'(enc(0, 1, 'h500)));

        // Stall then dry: release only once the output drains
        do_reset();
        base[0] = 'h600; len[0] = 3; drop_at[0] = 4;
        base[2] = 'h620; len[2] = 2;
        stall_lo = 3; stall_hi = 7;
        run(12);
        for (int c = 4; c < 7; c++)
            chk($sformatf("t6 no release c%0d", c), ptr_log[c], 0);
        chk("t6 ptr after release", ptr_log[8], 1);
        exp_q.push_back(enc(0, 0, 'h600)); exp_q.push_back(enc(0, 0, 'h601));
        exp_q.push_back(enc(0, 2, 'h620)); exp_q.push_back(enc(0, 2, 'h621));
        chk_words("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
